// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: streams a program into IMEM while the core is held in
// reset, drains for DRAIN_CYC cycles, then releases the core. Bad lengths and stalls park in ERR.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [10:0] prog_len,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        start,
  output logic        enable_inst_in,
  output logic [31:0] ADDRESS,
  output logic [31:0] INSTRUCTION,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 2);
  localparam int unsigned DRN_W = $clog2(DRAIN_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             start_q, start_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             beat;
  logic             len_ok;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    drn_d   = drn_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    instr_d = instr_q;
    beat    = (state_q == S_LOAD) && s_valid;
    len_ok  = (prog_len != 11'd0) && ({21'd0, prog_len} <= DEPTH);

    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req) begin
          if (len_ok) begin
            state_d = S_LOAD;
            // The last word index is kept instead of the length; it always fits the counter.
            last_d  = CNT_W'(prog_len - 11'd1);
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          start_d = 1'b1;
          addr_d  = 32'({cnt_q, 2'b00});
          instr_d = s_data;
          tmo_d   = '0;
          if (cnt_q == last_q) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_CYC - 1)) state_d = S_RUN;
        else                                drn_d   = drn_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      tmo_q   <= '0;
      drn_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      drn_q   <= drn_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign s_ready        = (state_q == S_LOAD);
  assign busy           = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done           = (state_q == S_RUN);
  assign err            = (state_q == S_ERR);
  assign core_rst_n     = (state_q == S_RUN);
  assign enable_inst_in = (state_q != S_RUN);
  assign start          = start_q;
  assign ADDRESS        = addr_q;
  assign INSTRUCTION    = instr_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: cycle vector table, directed corner sequences,
// and randomized programs compared against an expected write log.
module tb_imem_boot_ctrl;

  localparam int DEPTH     = 1024;
  localparam int TIMEOUT   = 255;
  localparam int DRAIN_CYC = 4;

  // Status order: {s_ready, start, core_rst_n, enable_inst_in, busy, done, err}
  localparam logic [6:0] ST_IDLE = 7'b0001000;
  localparam logic [6:0] ST_LD   = 7'b1001100;
  localparam logic [6:0] ST_LDB  = 7'b1101100;
  localparam logic [6:0] ST_DRB  = 7'b0101100;
  localparam logic [6:0] ST_DR   = 7'b0001100;
  localparam logic [6:0] ST_RUN  = 7'b0010010;
  localparam logic [6:0] ST_ERR  = 7'b0001001;

  localparam logic [31:0] W_A = 32'h0050_0093;
  localparam logic [31:0] W_B = 32'h0010_8113;
  localparam logic [31:0] W_C = 32'h0000_006F;
  localparam logic [31:0] W_D = 32'h1234_5678;
  localparam logic [31:0] W_E = 32'hDEAD_BEEF;
  localparam logic [31:0] W_X = 32'hFFFF_0000;

  typedef struct packed {
    logic        ld;
    logic [10:0] len;
    logic        sv;
    logic [31:0] dat;
    logic [6:0]  st;
    logic [31:0] addr;
    logic [31:0] instr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [10:0] prog_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready, start, enable_inst_in, core_rst_n, busy, done, err;
  logic [31:0] ADDRESS, INSTRUCTION;

  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl[$];
  logic [63:0] mon_q[$];
  logic [63:0] exp_q[$];
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_req       (load_req),
    .prog_len       (prog_len),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .start          (start),
    .enable_inst_in (enable_inst_in),
    .ADDRESS        (ADDRESS),
    .INSTRUCTION    (INSTRUCTION),
    .core_rst_n     (core_rst_n),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // Every write strobe is logged mid-cycle for the randomized phase.
  always @(negedge clk) if (mon_en && start) mon_q.push_back({ADDRESS, INSTRUCTION});

  function automatic logic [6:0] st_now();
    return {s_ready, start, core_rst_n, enable_inst_in, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic ld, input logic [10:0] len, input logic sv,
                         input logic [31:0] dat, input logic [6:0] st,
                         input logic [31:0] addr, input logic [31:0] instr);
    vec_t v;
    v.ld = ld; v.len = len; v.sv = sv; v.dat = dat;
    v.st = st; v.addr = addr; v.instr = instr;
    tbl.push_back(v);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(name, 128'(st_now()), 128'(ST_RUN));
  endtask

  task automatic beat(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic load(input logic [10:0] len);
    load_req = 1'b1;
    prog_len = len;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int len;
    int gap;
    int n;
    logic ok;

    rst = 1'b1; load_req = 1'b0; prog_len = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 128'({st_now(), ADDRESS, INSTRUCTION}), 128'({ST_IDLE, 32'h0, 32'h0}));
    rst = 1'b0;

    // ---- cycle table: 3-word load, drain, bad lengths, reload from ERR and from RUN ----
    add_vec(1, 11'd3,    0, 0,   ST_LD,   32'h0, 32'h0);
    add_vec(0, 11'd0,    1, W_A, ST_LDB,  32'h0, W_A);
    add_vec(1, 11'd0,    1, W_B, ST_LDB,  32'h4, W_B);
    add_vec(0, 11'd0,    1, W_C, ST_DRB,  32'h8, W_C);
    add_vec(0, 11'd0,    1, W_X, ST_DR,   32'h8, W_C);
    add_vec(1, 11'd0,    0, 0,   ST_DR,   32'h8, W_C);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h8, W_C);
    add_vec(0, 11'd0,    0, 0,   ST_RUN,  32'h8, W_C);
    add_vec(0, 11'd0,    1, W_X, ST_RUN,  32'h8, W_C);
    add_vec(1, 11'd0,    0, 0,   ST_ERR,  32'h8, W_C);
    add_vec(1, 11'd1025, 0, 0,   ST_ERR,  32'h8, W_C);
    add_vec(0, 11'd0,    1, W_X, ST_ERR,  32'h8, W_C);
    add_vec(1, 11'd1,    0, 0,   ST_LD,   32'h8, W_C);
    add_vec(0, 11'd0,    1, W_D, ST_DRB,  32'h0, W_D);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_D);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_D);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_D);
    add_vec(0, 11'd0,    0, 0,   ST_RUN,  32'h0, W_D);
    add_vec(1, 11'd1,    0, 0,   ST_LD,   32'h0, W_D);
    add_vec(0, 11'd0,    1, W_E, ST_DRB,  32'h0, W_E);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_E);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_E);
    add_vec(0, 11'd0,    0, 0,   ST_DR,   32'h0, W_E);
    add_vec(0, 11'd0,    0, 0,   ST_RUN,  32'h0, W_E);

    foreach (tbl[i]) begin
      load_req = tbl[i].ld;
      prog_len = tbl[i].len;
      s_valid  = tbl[i].sv;
      s_data   = tbl[i].dat;
      tick();
      check($sformatf("vec%0d", i), 128'({st_now(), ADDRESS, INSTRUCTION}),
            128'({tbl[i].st, tbl[i].addr, tbl[i].instr}));
    end
    load_req = 1'b0; s_valid = 1'b0;

    // ---- gap of 5 idle cycles between two beats ----
    load(11'd2);
    beat(32'hAAAA_0001);
    check("gap_w0", 128'({start, ADDRESS, INSTRUCTION}), 128'({1'b1, 32'h0, 32'hAAAA_0001}));
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (start || !s_ready) ok = 1'b0;
    end
    check("gap_quiet", 128'(ok), 128'(1'b1));
    beat(32'hAAAA_0002);
    check("gap_w1", 128'({start, ADDRESS, INSTRUCTION}), 128'({1'b1, 32'h4, 32'hAAAA_0002}));
    wait_done("gap_done", 20);

    // ---- stall after two of four beats -> timeout into ERR, then recover ----
    load(11'd4);
    beat(32'hBBBB_0000);
    beat(32'hBBBB_0001);
    c = 0;
    while (!err && c < 400) begin
      tick();
      c++;
    end
    check("tmo_cycles", 128'(c), 128'(TIMEOUT));
    check("tmo_err_state", 128'(st_now()), 128'(ST_ERR));
    load(11'd1);
    check("tmo_recover_ld", 128'(st_now()), 128'(ST_LD));
    beat(32'hBBBB_0002);
    check("tmo_recover_w", 128'({start, ADDRESS, INSTRUCTION}), 128'({1'b1, 32'h0, 32'hBBBB_0002}));
    wait_done("tmo_recover_done", 20);

    // ---- asynchronous reset in the middle of a 5-word load ----
    load(11'd5);
    beat(32'hCCCC_0000);
    beat(32'hCCCC_0001);
    s_valid = 1'b1;
    s_data  = 32'hCCCC_0002;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_load", 128'({st_now(), ADDRESS, INSTRUCTION}), 128'({ST_IDLE, 32'h0, 32'h0}));
    tick();
    tick();
    check("rst_hold", 128'({st_now(), ADDRESS, INSTRUCTION}), 128'({ST_IDLE, 32'h0, 32'h0}));
    rst = 1'b0;
    s_valid = 1'b0;
    load(11'd2);
    beat(32'hCCCC_0010);
    check("rst_reload_w0", 128'({start, ADDRESS}), 128'({1'b1, 32'h0}));
    beat(32'hCCCC_0011);
    check("rst_reload_w1", 128'({start, ADDRESS}), 128'({1'b1, 32'h4}));
    wait_done("rst_reload_done", 20);

    // ---- randomized programs with gaps and ignored requests against an expected write log ----
    mon_en = 1'b1;
    for (int p = 0; p < 20; p++) begin
      mon_q.delete();
      exp_q.delete();
      if ($urandom_range(0, 3) == 0) begin
        load(($urandom_range(0, 1) == 0) ? 11'd0 : 11'($urandom_range(1025, 2047)));
        check($sformatf("rnd%0d_bad_len", p), 128'(st_now()), 128'(ST_ERR));
      end
      len = $urandom_range(1, 12);
      load(11'(len));
      for (int w = 0; w < len; w++) begin
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 30) : $urandom_range(0, 2);
        repeat (gap) begin
          s_valid  = 1'b0;
          load_req = 1'($urandom_range(0, 1));
          prog_len = 11'($urandom);
          tick();
        end
        load_req = 1'($urandom_range(0, 1));
        prog_len = 11'($urandom);
        s_valid  = 1'b1;
        s_data   = $urandom;
        exp_q.push_back({32'(w * 4), s_data});
        tick();
      end
      n = 0;
      while (!core_rst_n && n < 20) begin
        s_valid  = 1'($urandom_range(0, 1));
        load_req = 1'($urandom_range(0, 1));
        prog_len = 11'($urandom);
        tick();
        n++;
      end
      load_req = 1'b0;
      s_valid  = 1'b0;
      check($sformatf("rnd%0d_drain", p), 128'(n), 128'(DRAIN_CYC));
      check($sformatf("rnd%0d_run", p), 128'(st_now()), 128'(ST_RUN));
      check($sformatf("rnd%0d_nwrites", p), 128'(mon_q.size()), 128'(exp_q.size()));
      foreach (exp_q[k]) begin
        if (k < mon_q.size())
          check($sformatf("rnd%0d_w%0d", p, k), 128'(mon_q[k]), 128'(exp_q[k]));
      end
    end
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the instruction memory size in 32-bit words.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum idle cycles allowed between accepted words during load.
REQ-003 The block SHALL have parameter DRAIN_CYC, default 4, giving the cycles the core is held in reset after load.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port load_req, input, 1 bit: pulse requesting a program load.
REQ-007 Port prog_len, input, 11 bits: word count, sampled when load_req is accepted.
REQ-008 Port s_valid, input, 1 bit: the instruction stream word is valid.
REQ-009 Port s_data, input, 32 bits: the instruction stream word.
REQ-010 Port s_ready, output, 1 bit: the block accepts a stream word.
REQ-011 Port start, output, 1 bit: instruction memory write strobe.
REQ-012 Port enable_inst_in, output, 1 bit: 1 = instruction memory addressed by ADDRESS, 0 = addressed by core PC.
REQ-013 Port ADDRESS, output, 32 bits: instruction memory byte address for the write.
REQ-014 Port INSTRUCTION, output, 32 bits: instruction memory write data.
REQ-015 Port core_rst_n, output, 1 bit: active-low reset to the pipeline datapath.
REQ-016 Ports busy, done and err, outputs, 1 bit each: status flags.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DRAIN, RUN and ERR.
REQ-018 A beat SHALL be s_valid AND s_ready on the same rising edge.
REQ-019 In IDLE or RUN, load_req SHALL be handled as follows:
- prog_len in 1..DEPTH: latch it, clear the word counter, timeout counter and err, then go to LOAD.
- otherwise: go to ERR.
REQ-020 In LOAD, s_ready SHALL be 1, busy SHALL be 1 and core_rst_n SHALL be 0.
REQ-021 Each beat SHALL produce, on the next cycle only, start=1, ADDRESS={count,2'b00} zero-extended and INSTRUCTION=s_data; the word counter then increments. Latency is 1 cycle.
REQ-022 start SHALL be 0 in every cycle that does not follow a beat.
REQ-023 The beat where count equals prog_len-1 SHALL move the FSM to DRAIN, and s_ready SHALL be 0 from the next cycle.
REQ-024 The timeout counter SHALL clear on each beat and increment on each LOAD cycle with no beat; when it reaches TIMEOUT the FSM SHALL go to ERR.
REQ-025 In DRAIN, core_rst_n SHALL stay 0 and enable_inst_in SHALL stay 1 for DRAIN_CYC cycles; the FSM then goes to RUN.
REQ-026 In RUN, core_rst_n SHALL be 1, enable_inst_in SHALL be 0, done SHALL be 1 and busy SHALL be 0.
REQ-027 load_req in RUN SHALL drive core_rst_n=0, enable_inst_in=1 and done=0 on the next cycle.
REQ-028 In ERR, err SHALL be 1, core_rst_n SHALL be 0, s_ready SHALL be 0 and busy SHALL be 0; err SHALL stay set until a valid load_req is accepted.
REQ-029 load_req SHALL be ignored in LOAD and DRAIN.
REQ-030 s_valid SHALL be ignored outside LOAD.
REQ-031 The word counter SHALL never exceed DEPTH-1, so ADDRESS never wraps.

Reset
REQ-032 While rst is high, and immediately on its assertion, the block SHALL drive:
- state IDLE
- core_rst_n=0, enable_inst_in=1
- start=0, s_ready=0
- ADDRESS=0, INSTRUCTION=0
- busy=0, done=0, err=0
- all counters 0
REQ-033 rst asserted mid-LOAD SHALL abort the load with no further start pulses; memory contents are not restored.

Verification
REQ-034 load_req with prog_len=3 and three back-to-back beats 0x00500093, 0x00108113, 0x0000006F -> start pulses at ADDRESS 0x0, 0x4, 0x8 with matching INSTRUCTION; s_ready=0 after the third beat; core_rst_n rises 4 cycles later with done=1 and enable_inst_in=0.
REQ-035 prog_len=2 with s_valid low for 5 cycles between beats -> no start during the gap; second write at ADDRESS 0x4; completes normally.
REQ-036 prog_len=4, two beats, then s_valid held low for 255 cycles -> ERR with err=1 and core_rst_n=0; a following load_req with prog_len=1 clears err and loads at ADDRESS 0x0.
REQ-037 load_req with prog_len=0 and with prog_len=1025 -> ERR each time, with no start pulse and s_ready=0.
REQ-038 Program running, then load_req with prog_len=1 -> the next cycle shows core_rst_n=0, done=0 and enable_inst_in=1; the word is written at ADDRESS 0x0.
REQ-039 rst asserted during LOAD after 2 of 5 beats -> all outputs take their reset values in the same cycle; the next load restarts at ADDRESS 0x0.
